serial_lookahead_addsub: RTL and testbench

Multi-cycle, parametrised add/subtract unit for wide operands. It processes CHUNK bits per cycle through a borrow/carry-lookahead slice and registers the borrow between chunks. It uses a start/busy/done handshake and reports borrow/carry-out, signed overflow and zero flags. It is the wide, sequential successor to the team's 4-bit lookahead subtractor and serves datapaths where a full-width single-cycle lookahead tree is too slow.

---
 rtl/serial_lookahead_addsub_pkg.sv | 19 +
 rtl/serial_lookahead_addsub_if.sv | 29 ++
 rtl/serial_lookahead_addsub_lookahead_slice.sv | 45 ++++
 rtl/serial_lookahead_addsub.sv | 138 +++++++++++++
 tb/tb_serial_lookahead_addsub.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_lookahead_addsub_pkg.sv
// Shared types and helpers for the serial lookahead add/subtract unit.
// Imported by the slice, the top level and the bench.
package serial_lookahead_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_ADD = 1'b1;

    // Guarded so a bad CHUNK reaches the elaboration error, not a divide by zero
    function automatic int nchunk(input int width, input int chunk);
        return (chunk < 1) ? 1 : width / chunk;
    endfunction

endpackage

// File: rtl/serial_lookahead_addsub_if.sv
// Request/result bundle of the serial lookahead add/subtract unit.
// The master drives the operands and start; the slave returns status and results.
interface serial_lookahead_addsub_if #(
    parameter int WIDTH = 16
) ();

    logic             start;
    logic             mode;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Ovf;
    logic             Zero;

    modport master (
        output start, mode, X, Y, Bin,
        input  busy, done, Diff, Bout, Ovf, Zero
    );

    modport slave (
        input  start, mode, X, Y, Bin,
        output busy, done, Diff, Bout, Ovf, Zero
    );

endinterface

// File: rtl/serial_lookahead_addsub_lookahead_slice.sv
// Combinational CHUNK-bit borrow/carry lookahead slice.
// Every internal borrow is a flat sum of products of g, p and bin.
module lookahead_slice
    import serial_lookahead_addsub_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             bin,
    input  logic             mode,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    logic [CHUNK-1:0] t;
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   b;
    logic             term;

    assign t = x ^ y;
    assign g = (mode == MODE_SUB) ? (~x & y) : (x & y);
    assign p = (mode == MODE_SUB) ? ~t : t;

    // b[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]bin
    always_comb begin
        b    = '0;
        term = 1'b0;
        for (int i = 0; i <= CHUNK; i++) begin
            term = bin;
            for (int j = 0; j < i; j++) term = term & p[j];
            b[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) term = term & p[k];
                b[i] = b[i] | term;
            end
        end
    end

    assign d    = t ^ b[CHUNK-1:0];
    assign bout = b[CHUNK];

endmodule

// File: rtl/serial_lookahead_addsub.sv
// Multi-cycle add/subtract: CHUNK bits per cycle through a lookahead slice,
// borrow registered between chunks, results published only on completion.
module serial_lookahead_addsub
    import serial_lookahead_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    serial_lookahead_addsub_if.slave bus
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (CHUNK < 1) begin : g_bad_chunk
        $error("serial_lookahead_addsub: CHUNK must be >= 1");
    end else if (WIDTH % CHUNK != 0) begin : g_bad_width
        $error("serial_lookahead_addsub: WIDTH must be a multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             mode_q, mode_d;
    logic             b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [CHUNK-1:0] sd;
    logic             sb;
    logic [WIDTH-1:0] res_nx;
    logic             last;
    logic             take;
    logic             xm, ym, dm;

    lookahead_slice #(
        .CHUNK(CHUNK)
    ) u_slice (
        .x   (xs_q[CHUNK-1:0]),
        .y   (ys_q[CHUNK-1:0]),
        .bin (b_q),
        .mode(mode_q),
        .d   (sd),
        .bout(sb)
    );

    // Result chunks enter at the top and move down, so chunk 0 ends at the LSBs
    assign res_nx = (res_q >> CHUNK) | (WIDTH'(sd) << (WIDTH - CHUNK));
    assign last   = (k_q == KW'(NCHUNK - 1));
    assign take   = bus.start && (state_q != RUN);
    assign xm     = xs_q[CHUNK-1];
    assign ym     = ys_q[CHUNK-1];
    assign dm     = sd[CHUNK-1];

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        res_d   = res_q;
        mode_d  = mode_q;
        b_d     = b_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        unique case (state_q)
            IDLE: state_d = IDLE;
            RUN: begin
                xs_d  = xs_q >> CHUNK;
                ys_d  = ys_q >> CHUNK;
                res_d = res_nx;
                b_d   = sb;
                k_d   = k_q + KW'(1);
                if (last) begin
                    state_d = DONE;
                    diff_d  = res_nx;
                    bout_d  = sb;
                    zero_d  = (res_nx == '0);
                    ovf_d   = (mode_q == MODE_ADD) ? ((xm == ym) && (dm != xm))
                                                   : ((xm != ym) && (dm != xm));
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (take) begin
            state_d = RUN;
            k_d     = '0;
            xs_d    = bus.X;
            ys_d    = bus.Y;
            mode_d  = bus.mode;
            b_d     = bus.Bin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            xs_q    <= '0;
            ys_q    <= '0;
            res_q   <= '0;
            mode_q  <= 1'b0;
            b_q     <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            res_q   <= res_d;
            mode_q  <= mode_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.Diff = diff_q;
    assign bus.Bout = bout_q;
    assign bus.Ovf  = ovf_q;
    assign bus.Zero = zero_q;

endmodule

// File: tb/tb_serial_lookahead_addsub.sv
// Bench for serial_lookahead_addsub: CHUNK = 4, 1 and 16 side by side,
// directed table, hand-written handshake/reset sequences, random regression.
module tb_serial_lookahead_addsub;
    import serial_lookahead_addsub_pkg::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    serial_lookahead_addsub_if #(.WIDTH(16)) if4 ();
    serial_lookahead_addsub_if #(.WIDTH(16)) if1 ();
    serial_lookahead_addsub_if #(.WIDTH(16)) if16 ();

    serial_lookahead_addsub #(.WIDTH(16), .CHUNK(4)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(if4));
    serial_lookahead_addsub #(.WIDTH(16), .CHUNK(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));
    serial_lookahead_addsub #(.WIDTH(16), .CHUNK(16)) u16 (
        .clk(clk), .rst_n(rst_n), .bus(if16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // index 0: CHUNK=4, 1: CHUNK=1, 2: CHUNK=16
    logic [2:0]  dn, bz, bo, ov, zr;
    logic [15:0] df [3];
    int          nch[3];
    logic [15:0] last_diff[3];

    assign dn    = {if16.done, if1.done, if4.done};
    assign bz    = {if16.busy, if1.busy, if4.busy};
    assign bo    = {if16.Bout, if1.Bout, if4.Bout};
    assign ov    = {if16.Ovf,  if1.Ovf,  if4.Ovf};
    assign zr    = {if16.Zero, if1.Zero, if4.Zero};
    assign df[0] = if4.Diff;
    assign df[1] = if1.Diff;
    assign df[2] = if16.Diff;

    typedef struct {
        string       name;
        logic        m;
        logic [15:0] x;
        logic [15:0] y;
        logic        b;
        logic [15:0] ed;
        logic        eb;
        logic        eo;
        logic        ez;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic m, input logic [15:0] x, input logic [15:0] y,
                          input logic b);
        if4.mode  = m; if4.X  = x; if4.Y  = y; if4.Bin  = b;
        if1.mode  = m; if1.X  = x; if1.Y  = y; if1.Bin  = b;
        if16.mode = m; if16.X = x; if16.Y = y; if16.Bin = b;
    endtask

    task automatic set_start(input logic s);
        if4.start = s; if1.start = s; if16.start = s;
    endtask

    // Reference: plain integer arithmetic, {zero, ovf, bout, diff}
    function automatic logic [18:0] model(input logic m, input logic [15:0] x,
                                          input logic [15:0] y, input logic b);
        int          u, s, xs, ys, bi;
        logic [15:0] d;
        logic        bt, o;
        bi = b ? 1 : 0;
        xs = int'($signed(x));
        ys = int'($signed(y));
        if (m == MODE_ADD) begin
            u  = int'(x) + int'(y) + bi;
            s  = xs + ys + bi;
            bt = (u > 65535);
        end else begin
            u  = int'(x) - int'(y) - bi;
            s  = xs - ys - bi;
            bt = (u < 0);
        end
        d = u[15:0];
        o = (s > 32767) || (s < -32768);
        return {(d == 16'h0), o, bt, d};
    endfunction

    task automatic run_op(input logic m, input logic [15:0] x, input logic [15:0] y,
                          input logic b, input logic [15:0] ed, input logic eb,
                          input logic eo, input logic ez, input string nm);
        int          lat[3], bc[3], pc[3], hb[3];
        logic [15:0] gd[3];
        logic        gb[3], go[3], gz[3];
        for (int i = 0; i < 3; i++) begin
            lat[i] = -1; bc[i] = 0; pc[i] = 0; hb[i] = 0;
            gd[i] = '0; gb[i] = 1'b0; go[i] = 1'b0; gz[i] = 1'b0;
        end
        @(negedge clk);
        set_in(m, x, y, b);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        set_in(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (dn[i]) begin
                    pc[i]++;
                    if (lat[i] < 0) begin
                        lat[i] = c; gd[i] = df[i];
                        gb[i] = bo[i]; go[i] = ov[i]; gz[i] = zr[i];
                    end
                end
                if (lat[i] < 0) begin
                    if (bz[i]) bc[i]++;
                    if (df[i] != last_diff[i]) hb[i]++;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            string t;
            t = $sformatf("%s[c%0d]", nm, 16 / nch[i]);
            chk({t, ".diff"},    32'(gd[i]),  32'(ed));
            chk({t, ".bout"},    32'(gb[i]),  32'(eb));
            chk({t, ".ovf"},     32'(go[i]),  32'(eo));
            chk({t, ".zero"},    32'(gz[i]),  32'(ez));
            chk({t, ".latency"}, 32'(lat[i]), 32'(nch[i]));
            chk({t, ".busy"},    32'(bc[i]),  32'(nch[i]));
            chk({t, ".pulses"},  32'(pc[i]),  32'd1);
            chk({t, ".hold"},    32'(hb[i]),  32'd0);
            last_diff[i] = ed;
        end
    endtask

    initial begin
        logic [18:0] r;
        logic        m, b;
        logic [15:0] x, y;
        int          c, cnt;
        tests = 0;
        fails = 0;
        nch[0] = 4; nch[1] = 16; nch[2] = 1;
        for (int i = 0; i < 3; i++) last_diff[i] = '0;

        vecs[0] = '{"s1_sub",     MODE_SUB, 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"s2_ripple",  MODE_SUB, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{"s2_ovf",     MODE_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"s3_carry",   MODE_ADD, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{"s3_ovf",     MODE_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{"s4_binsub",  MODE_SUB, 16'h5555, 16'h5555, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        set_start(1'b0);
        set_in(1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset.busy", 32'(bz), 32'd0);
        chk("reset.done", 32'(dn), 32'd0);
        chk("reset.diff", 32'(if4.Diff), 32'd0);
        chk("reset.bout", 32'(bo), 32'd0);
        chk("reset.ovf",  32'(ov), 32'd0);
        chk("reset.zero", 32'(zr), 32'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++)
            run_op(vecs[v].m, vecs[v].x, vecs[v].y, vecs[v].b,
                   vecs[v].ed, vecs[v].eb, vecs[v].eo, vecs[v].ez, vecs[v].name);

        // Restart during RUN is ignored; restart during DONE chains with no gap
        @(negedge clk);
        set_in(MODE_SUB, 16'h1234, 16'h0234, 1'b0);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        repeat (2) @(negedge clk);
        set_in(MODE_SUB, 16'hFFFF, 16'h0001, 1'b0);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        c = 3;
        while (!if4.done && c < 12) begin
            @(negedge clk);
            c++;
        end
        chk("s5_ignore.latency", 32'(c), 32'd4);
        chk("s5_ignore.diff", 32'(if4.Diff), 32'h1000);
        set_in(MODE_ADD, 16'h0001, 16'h0002, 1'b0);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        chk("s5_b2b.nogap_busy", 32'(if4.busy), 32'd1);
        chk("s5_b2b.nogap_done", 32'(if4.done), 32'd0);
        c = 0;
        while (!if4.done && c < 12) begin
            @(negedge clk);
            c++;
        end
        chk("s5_b2b.latency", 32'(c), 32'd4);
        chk("s5_b2b.diff", 32'(if4.Diff), 32'h0003);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        set_in(MODE_SUB, 16'h0000, 16'h0001, 1'b0);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst.diff", 32'(if4.Diff), 32'd0);
        chk("s6_rst.busy", 32'(if4.busy), 32'd0);
        chk("s6_rst.flags", 32'({if4.done, if4.Bout, if4.Ovf, if4.Zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dn != 3'b000) cnt++;
        end
        chk("s6_rst.no_done", 32'(cnt), 32'd0);
        for (int i = 0; i < 3; i++) last_diff[i] = '0;
        run_op(MODE_SUB, 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0, "s6_after");

        for (int n = 0; n < 40; n++) begin
            m = 1'($urandom);
            b = 1'($urandom);
            x = 16'($urandom);
            y = 16'($urandom);
            if ($urandom_range(0, 5) == 0) x = (n % 2 == 0) ? 16'hFFFF : 16'h8000;
            if ($urandom_range(0, 5) == 0) y = (n % 3 == 0) ? 16'h0000 : 16'h7FFF;
            if ($urandom_range(0, 7) == 0) y = x;
            r = model(m, x, y, b);
            run_op(m, x, y, b, r[15:0], r[16], r[17], r[18], $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
